// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory line arbiter.
// Port 0 is the instruction-cache refill port, port 1 the data-cache port.
package mem_arb_pkg;

   localparam int DEF_DATA_W = 256;
   localparam int DEF_ADDR_W = 32;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the two request lines.
// Define MEM_ARB_RR_EN to break ties round-robin; otherwise port 1 always wins ties.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic p0_req_i,
   input  logic p1_req_i,
   input  logic last_i,
   output logic winner_o,
   output logic valid_o
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      valid_o  = p0_req_i | p1_req_i;
      winner_o = PORT_I;
      // On a tie the port that was not served last goes next
      if (p0_req_i && p1_req_i) begin
         winner_o = ~last_i;
      end else if (p1_req_i) begin
         winner_o = PORT_D;
      end
   end
`else
   logic unused_last;
   assign unused_last = last_i;

   always_comb begin
      valid_o  = p0_req_i | p1_req_i;
      winner_o = p1_req_i ? PORT_D : PORT_I;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the off-chip Data Memory line interface between I-cache and D-cache.
// Build option MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed priority to port 1.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_data_i,
   output logic [DATA_W-1:0] p0_data_o,
   output logic              p0_ack_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_data_i,
   output logic [DATA_W-1:0] p1_data_o,
   output logic              p1_ack_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o
);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              mem_enable_q, mem_enable_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              last_served;
   logic              pick_winner;
   logic              pick_valid;

   mem_arb_pick u_pick (
      .p0_req_i (p0_enable_i),
      .p1_req_i (p1_enable_i),
      .last_i   (last_served),
      .winner_o (pick_winner),
      .valid_o  (pick_valid)
   );

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;
   assign last_d      = (state_q == IDLE && pick_valid) ? pick_winner : last_q;
   assign last_served = last_q;
`else
   assign last_served = PORT_I;
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      mem_enable_d = mem_enable_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d      = BUSY;
               owner_d      = pick_winner;
               mem_enable_d = 1'b1;
               if (pick_winner == PORT_D) begin
                  mem_write_d = p1_write_i;
                  mem_addr_d  = p1_addr_i;
                  mem_data_d  = p1_data_i;
               end else begin
                  mem_write_d = p0_write_i;
                  mem_addr_d  = p0_addr_i;
                  mem_data_d  = p0_data_i;
               end
            end
         end
         BUSY: begin
            if (mem_ack_i) begin
               state_d      = DONE;
               mem_enable_d = 1'b0;
               mem_write_d  = 1'b0;
            end
         end
         // Turnaround cycle: the owner's enable is still high here and must not be re-granted
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         owner_q      <= PORT_I;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
`ifdef MEM_ARB_RR_EN
         last_q       <= PORT_I;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
`ifdef MEM_ARB_RR_EN
         last_q       <= last_d;
`endif
      end
   end

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

   assign p0_ack_o  = (state_q == BUSY) && mem_ack_i && (owner_q == PORT_I);
   assign p1_ack_o  = (state_q == BUSY) && mem_ack_i && (owner_q == PORT_D);
   assign p0_data_o = mem_data_i;
   assign p1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized traffic
// against a transaction-level reference model (grant windows, ownership, latched request).
module tb_mem_arbiter;

   localparam int DW = 256;
   localparam int AW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          p0_enable_i = 1'b0, p0_write_i = 1'b0;
   logic [AW-1:0] p0_addr_i = '0;
   logic [DW-1:0] p0_data_i = '0;
   logic [DW-1:0] p0_data_o;
   logic          p0_ack_o;
   logic          p1_enable_i = 1'b0, p1_write_i = 1'b0;
   logic [AW-1:0] p1_addr_i = '0;
   logic [DW-1:0] p1_data_i = '0;
   logic [DW-1:0] p1_data_o;
   logic          p1_ack_o;
   logic [DW-1:0] mem_data_i = '0;
   logic          mem_ack_i = 1'b0;
   logic [DW-1:0] mem_data_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_enable_o, mem_write_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one outstanding transaction, and the earliest cycle a new grant may happen
   int            cyc = 0;
   int            next_ok = 0;
   bit            m_out = 0;
   bit            m_owner = 0;
   bit            m_last = 0;
   bit            m_wr = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;

   always #5 clk_i = ~clk_i;

   mem_arbiter dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .p0_enable_i  (p0_enable_i),
      .p0_write_i   (p0_write_i),
      .p0_addr_i    (p0_addr_i),
      .p0_data_i    (p0_data_i),
      .p0_data_o    (p0_data_o),
      .p0_ack_o     (p0_ack_o),
      .p1_enable_i  (p1_enable_i),
      .p1_write_i   (p1_write_i),
      .p1_addr_i    (p1_addr_i),
      .p1_data_i    (p1_data_i),
      .p1_data_o    (p1_data_o),
      .p1_ack_o     (p1_ack_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i),
      .mem_data_o   (mem_data_o),
      .mem_addr_o   (mem_addr_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o)
   );

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out   = 0;
      m_owner = 0;
      m_last  = 0;
      m_wr    = 0;
      m_addr  = '0;
      m_data  = '0;
      next_ok = 0;
   endtask

   // Advance the model by one clock edge using the inputs presented during the cycle
   task automatic model_edge();
      bit win;
      cyc++;
      if (!rst_i) begin
         model_reset();
      end else if (m_out) begin
         if (mem_ack_i) begin
            m_out   = 0;
            next_ok = cyc + 2;
         end
      end else if (cyc >= next_ok && (p0_enable_i || p1_enable_i)) begin
         if (p0_enable_i && p1_enable_i) begin
`ifdef MEM_ARB_RR_EN
            win = !m_last;
`else
            win = 1'b1;
`endif
         end else begin
            win = p1_enable_i;
         end
         m_out   = 1;
         m_owner = win;
         m_last  = win;
         m_wr    = win ? p1_write_i : p0_write_i;
         m_addr  = win ? p1_addr_i  : p0_addr_i;
         m_data  = win ? p1_data_i  : p0_data_i;
      end
   endtask

   task automatic check_against_model();
      checkOutput("mem_enable", mem_enable_o, m_out);
      checkOutput("mem_write",  mem_write_o,  m_out && m_wr);
      checkOutput("mem_addr",   mem_addr_o,   m_addr);
      checkOutput("mem_data",   mem_data_o,   m_data);
      checkOutput("p0_ack",     p0_ack_o,     m_out && mem_ack_i && !m_owner);
      checkOutput("p1_ack",     p1_ack_o,     m_out && mem_ack_i && m_owner);
      checkOutput("p0_data",    p0_data_o,    mem_data_i);
      checkOutput("p1_data",    p1_data_o,    mem_data_i);
   endtask

   // One clock: model follows the edge, new inputs go on at the falling edge, outputs checked just after
   task automatic applyStimulus(
      input logic e0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
      input logic e1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
      input logic mack);
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      p0_enable_i = e0; p0_write_i = w0; p0_addr_i = a0; p0_data_i = d0;
      p1_enable_i = e1; p1_write_i = w1; p1_addr_i = a1; p1_data_i = d1;
      mem_ack_i   = mack;
      mem_data_i  = rand_line();
      #1;
      check_against_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
   endtask

   initial begin
      logic [DW-1:0] line_a5;
      logic [AW-1:0] a0_r;
      bit            exp_win [3];
      bit            en [2];
      bit            wr [2];
      bit            acked [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] dt [2];
      logic          mack;
      int            wait_cnt;

      line_a5 = {32{8'hA5}};
`ifdef MEM_ARB_RR_EN
      exp_win = '{1'b1, 1'b0, 1'b1};
`else
      exp_win = '{1'b1, 1'b1, 1'b1};
`endif

      // Reset values
      model_reset();
      idle(2);
      checkOutput("rst_enable", mem_enable_o, 1'b0);
      checkOutput("rst_addr",   mem_addr_o,   '0);
      rst_i = 1'b1;
      idle(1);

      // Single read on port 0, memory answers 10 cycles after the request
      applyStimulus(1, 0, 32'h400, '0, 0, 0, '0, '0, 0);
      applyStimulus(1, 0, 32'h400, '0, 0, 0, '0, '0, 0);
      checkOutput("rd_enable", mem_enable_o, 1'b1);
      checkOutput("rd_addr",   mem_addr_o,   32'h400);
      checkOutput("rd_write",  mem_write_o,  1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 32'h400, '0, 0, 0, '0, '0, 0);
      applyStimulus(1, 0, 32'h400, '0, 0, 0, '0, '0, 1);
      checkOutput("rd_p0_ack", p0_ack_o, 1'b1);
      checkOutput("rd_p1_ack", p1_ack_o, 1'b0);
      idle(2);

      // Single write on port 1; port 0 asks right after the ack to measure the turnaround
      applyStimulus(0, 0, '0, '0, 1, 1, 32'h20, line_a5, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, '0, '0, 1, 1, 32'h20, line_a5, 0);
         checkOutput("wr_write", mem_write_o, 1'b1);
         checkOutput("wr_data",  mem_data_o,  line_a5);
      end
      applyStimulus(0, 0, '0, '0, 1, 1, 32'h20, line_a5, 1);
      checkOutput("wr_p1_ack", p1_ack_o, 1'b1);
      applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, '0, 0);
      checkOutput("done_enable", mem_enable_o, 1'b0);
      applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, '0, 0);
      checkOutput("turn_enable", mem_enable_o, 1'b0);
      applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, '0, 0);
      checkOutput("regrant_enable", mem_enable_o, 1'b1);
      checkOutput("regrant_addr",   mem_addr_o,   32'h40);
      applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, '0, 1);
      idle(2);

      // Simultaneous requests three times from a fresh reset; port 0 wiggles addr/data while busy
      rst_i = 1'b0;
      idle(1);
      rst_i = 1'b1;
      for (int r = 0; r < 3; r++) begin
         a0_r = 32'h800;
         applyStimulus(1, 0, a0_r, '0, 1, 0, 32'h100 + 32'(r * 32), '0, 0);
         for (int i = 0; i < 3; i++) begin
            a0_r = $urandom();
            applyStimulus(1, 0, a0_r, rand_line(), 1, 0, 32'h100 + 32'(r * 32), '0, 0);
            checkOutput("tie_addr_hold", mem_addr_o, exp_win[r] ? 32'h100 + 32'(r * 32) : 32'h800);
         end
         applyStimulus(1, 0, a0_r, '0, 1, 0, 32'h100 + 32'(r * 32), '0, 1);
         checkOutput("tie_winner", {p1_ack_o, p0_ack_o}, exp_win[r] ? 2'b10 : 2'b01);
         idle(2);
      end

      // Spurious memory ack while idle
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 1);
      checkOutput("spur_p0_ack", p0_ack_o, 1'b0);
      checkOutput("spur_p1_ack", p1_ack_o, 1'b0);
      idle(1);
      checkOutput("spur_enable", mem_enable_o, 1'b0);

      // Reset three cycles into a busy write, then a late ack and a fresh request
      applyStimulus(1, 1, 32'h1000, line_a5, 0, 0, '0, '0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'h1000, line_a5, 0, 0, '0, '0, 0);
      #2 rst_i = 1'b0;
      #1;
      model_reset();
      checkOutput("arst_enable", mem_enable_o, 1'b0);
      checkOutput("arst_write",  mem_write_o,  1'b0);
      checkOutput("arst_addr",   mem_addr_o,   '0);
      checkOutput("arst_data",   mem_data_o,   '0);
      idle(1);
      rst_i = 1'b1;
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 1);
      checkOutput("late_p0_ack", p0_ack_o, 1'b0);
      applyStimulus(1, 0, 32'h2000, '0, 0, 0, '0, '0, 0);
      applyStimulus(1, 0, 32'h2000, '0, 0, 0, '0, '0, 0);
      checkOutput("post_rst_enable", mem_enable_o, 1'b1);
      checkOutput("post_rst_addr",   mem_addr_o,   32'h2000);
      applyStimulus(1, 0, 32'h2000, '0, 0, 0, '0, '0, 1);
      idle(2);

      // Randomized traffic: requesters hold until acked, memory answers after a random delay
      for (int p = 0; p < 2; p++) begin
         en[p] = 0; wr[p] = 0; acked[p] = 0; ad[p] = '0; dt[p] = '0;
      end
      wait_cnt = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (en[p] && acked[p]) begin
               en[p] = 0;
            end else if (!en[p] && $urandom_range(0, 2) == 0) begin
               en[p] = 1;
               wr[p] = $urandom_range(0, 1) == 1;
               ad[p] = $urandom() & 32'hFFFF_FFE0;
               dt[p] = rand_line();
            end else if (en[p] && $urandom_range(0, 3) == 0) begin
               ad[p] = $urandom() & 32'hFFFF_FFE0;
               dt[p] = rand_line();
            end
         end
         mack = 1'b0;
         if (m_out) begin
            if (wait_cnt == 0) begin
               mack     = 1'b1;
               wait_cnt = $urandom_range(0, 4);
            end else begin
               wait_cnt--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            mack = 1'b1;
         end
         applyStimulus(en[0], wr[0], ad[0], dt[0], en[1], wr[1], ad[1], dt[1], mack);
         acked[0] = m_out && mack && !m_owner;
         acked[1] = m_out && mack && m_owner;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single off-chip Data Memory line interface (256-bit line, 32-bit address, enable/write, ack) between the instruction-cache refill port (port 0) and the data-cache refill/write-back port (port 1). It sits between both cache controllers and the memory model. It registers the winning request, holds it stable until the memory acks, and routes the ack back to the owner only.

## Interface
Parameters:
- DATA_W, 256, memory line width
- ADDR_W, 32, byte address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- p0_enable_i / p1_enable_i  in  1  request; held high until own ack
- p0_write_i / p1_write_i  in  1  1 = write line, 0 = read line
- p0_addr_i / p1_addr_i  in  ADDR_W  line address
- p0_data_i / p1_data_i  in  DATA_W  write line
- p0_data_o / p1_data_o  out  DATA_W  read line; equals mem_data_i
- p0_ack_o / p1_ack_o  out  1  transaction done; owner only
- mem_data_i  in  DATA_W  read line from memory
- mem_ack_i  in  1  memory done; one-cycle pulse
- mem_data_o  out  DATA_W  registered write line
- mem_addr_o  out  ADDR_W  registered address
- mem_enable_o  out  1  registered request to memory
- mem_write_o  out  1  registered write flag

## Operation
- FSM states:
  - IDLE: grant selection.
  - BUSY: transaction outstanding.
  - DONE: one-cycle turnaround.
- IDLE, any enable high:
  - select owner; latch that port's addr, data and write into the mem_* registers.
  - set mem_enable_o = 1.
  - go to BUSY.
- BUSY:
  - mem_* outputs held constant; new requests ignored.
  - On mem_ack_i = 1: pX_ack_o = 1 for the owner, combinationally, same cycle.
  - At that edge: clear mem_enable_o and mem_write_o, go to DONE.
- DONE: no sampling of requests; go to IDLE. This guarantees the requester's enable, dropped after ack, is never re-granted.
- Both enables high in IDLE: port 1 (data) wins under fixed priority; see Configuration.
- mem_ack_i in IDLE or DONE is ignored; no pX_ack_o is produced.
- Non-owner ack is always 0.
- Both pX_data_o are driven by mem_data_i unconditionally; requesters qualify with their own ack.
- A requester dropping enable while BUSY does not abort the transaction; the arbiter still waits for mem_ack_i.
- Reset mid-transaction:
  - state returns to IDLE; all registered outputs clear.
  - the in-flight memory transaction is abandoned; its late ack is ignored per the IDLE rule.

## Timing
- Reset values:
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - p0_ack_o = 0, p1_ack_o = 0; owner = port 0; last-served = port 0.
- Grant latency: request sampled at edge N in IDLE gives mem_enable_o high from edge N+1.
- Ack passthrough: 0 cycles, combinational from mem_ack_i.
- Minimum period between grants: request cycle + BUSY cycles + 1 DONE cycle.
- Back-to-back example: edge N+k samples ack → DONE during N+k+1 → the next grant is sampled at edge N+k+2.

## Configuration
- MEM_ARB_RR_EN defined:
  - round-robin on simultaneous requests; the port not served last wins.
  - a last-served flag updates at each grant.
- MEM_ARB_RR_EN undefined:
  - fixed priority, port 1 always wins ties.
  - last-served flag not implemented.
- Single-requester behaviour is identical in both builds.

## Structure
- Package mem_arb_pkg holds:
  - state encoding IDLE/BUSY/DONE (2-bit);
  - port-id constants PORT_I = 0, PORT_D = 1;
  - DATA_W/ADDR_W defaults.
- Sub-module mem_arb_pick: combinational winner select (inputs: two enables, last-served flag; output: winner id, valid). The round-robin logic is isolated here under MEM_ARB_RR_EN.
- The top level holds the FSM, output registers and ack routing.

## Test plan
- Single read, port 0, addr 0x0000_0400; memory acks 10 cycles later:
  - mem_enable_o high 1 cycle after request; mem_addr_o = 0x400, mem_write_o = 0;
  - p0_ack_o pulses with mem_ack_i; p1_ack_o stays 0.
- Single write, port 1, addr 0x0000_0020, data = all 0xA5:
  - mem_write_o = 1 and mem_data_o = all 0xA5 held stable through ack;
  - DONE lasts exactly 1 cycle.
- Simultaneous requests, fixed build, repeated 3 times: port 1 is served each time. RR build: order 1, 0, 1 (last-served reset = 0).
- Port 0 changes addr/data while BUSY (port 1 owner): mem_addr_o and mem_data_o unchanged until ack.
- Spurious mem_ack_i in IDLE: no pX_ack_o, no state change.
- rst_i low 3 cycles into BUSY:
  - all outputs 0 immediately (asynchronous);
  - a late mem_ack_i after reset release is ignored;
  - a new port 0 request is granted normally.
